// File: rtl/regfile_pkg.sv
// Shared register-file constants: default geometry and the hard-wired zero address
// used by the regfile and by decode/hazard logic elsewhere in the datapath.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NRD    = 2;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_rd_mux.sv
// One read port of the register file: NREG:1 word multiplexer over the flattened array.
module regfile_rd_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] i_words,
  input  logic [ADDR_W-1:0]             i_sel,
  output logic [DATA_W-1:0]             o_data_c
);

  localparam int unsigned NREG = 2**ADDR_W;

  always_comb begin
    o_data_c = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (i_sel == ADDR_W'(k)) begin
        o_data_c = i_words[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_nrd_1wr.sv
// NREG x DATA_W register file with one write port and NRD read ports; optional zero
// register, write-to-read bypass and registered read outputs.
module regfile_nrd_1wr
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NRD      = DEF_NRD,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned RD_LAT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [DATA_W-1:0]      r_mem [NREG];
  logic [NRD*DATA_W-1:0]  r_rdata;

  logic                   w_wr_en;
  logic [NREG-1:0]        w_wdec;
  logic [NREG*DATA_W-1:0] w_words;
  logic [NRD*DATA_W-1:0]  w_rd;

  // Write qualification and one-hot decode; writes to the zero register never land.
  always_comb begin
    w_wr_en = rst_n && we && !((ZERO_REG != 0) && (waddr == ADDR_W'(REG_ZERO)));
    w_wdec  = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      w_wdec[k] = w_wr_en && (waddr == ADDR_W'(k));
    end
  end

  // Storage and optional output registers; reset wins over any same-edge write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NREG; k++) begin
        r_mem[k] <= '0;
      end
      r_rdata <= '0;
    end else begin
      for (int unsigned k = 0; k < NREG; k++) begin
        if (w_wdec[k]) begin
          r_mem[k] <= wdata;
        end
      end
      if (RD_LAT != 0) begin
        r_rdata <= w_rd;
      end
    end
  end

  // Word 0 is tied off when it is the zero register so the muxes see a constant.
  for (genvar k = 0; k < NREG; k++) begin : g_word
    assign w_words[k*DATA_W +: DATA_W] = ((ZERO_REG != 0) && (k == 0)) ? '0 : r_mem[k];
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_mux;
    logic              w_hit;

    assign w_addr = raddr[p*ADDR_W +: ADDR_W];

    regfile_rd_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd_mux (
      .i_words  (w_words),
      .i_sel    (w_addr),
      .o_data_c (w_mux)
    );

    assign w_hit = (BYPASS != 0) && w_wr_en && (w_addr == waddr);
    assign w_rd[p*DATA_W +: DATA_W] = w_hit ? wdata : w_mux;
  end

  assign rdata = (RD_LAT != 0) ? r_rdata : w_rd;

endmodule

// File: tb/tb_regfile_nrd_1wr.sv
// Scoreboard bench: three regfile configurations share one write stream and are
// checked against hand-computed expectations queued by the stimulus process.
module tb_regfile_nrd_1wr;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [3*AW-1:0] raddr;
  logic [2*DW-1:0] rdata_a;
  logic [3*DW-1:0] rdata_b;
  logic [2*DW-1:0] rdata_c;

  always #5 clk = ~clk;

  // A: bypass, combinational read
  regfile_nrd_1wr #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .ZERO_REG(1), .BYPASS(1), .RD_LAT(0))
    u_dut_a (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
             .raddr(raddr[2*AW-1:0]), .rdata(rdata_a));

  // B: three ports, no bypass, combinational read
  regfile_nrd_1wr #(.DATA_W(DW), .ADDR_W(AW), .NRD(3), .ZERO_REG(1), .BYPASS(0), .RD_LAT(0))
    u_dut_b (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
             .raddr(raddr), .rdata(rdata_b));

  // C: bypass, registered read
  regfile_nrd_1wr #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .ZERO_REG(1), .BYPASS(1), .RD_LAT(1))
    u_dut_c (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
             .raddr(raddr[2*AW-1:0]), .rdata(rdata_c));

  typedef struct {
    int            dut;
    int            port;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    total = 0;
  int    bad = 0;
  int    req = 0;
  int    ack = 0;
  int    cycles = 0;
  bit    stim_done = 1'b0;

  function automatic logic [DW-1:0] pat(input int i);
    logic [DW-1:0] m;
    m = 32'h0101_0101;
    return (i == 0) ? '0 : DW'(i) * m;
  endfunction

  function automatic logic [DW-1:0] got(input int d, input int p);
    case (d)
      0:       return rdata_a[p*DW +: DW];
      1:       return rdata_b[p*DW +: DW];
      default: return rdata_c[p*DW +: DW];
    endcase
  endfunction

  task automatic push(input int d, input int p, input logic [DW-1:0] e, input string n);
    exp_t x;
    x.dut  = d;
    x.port = p;
    x.exp  = e;
    sb.push_back(x);
    sb_name.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk();
    req++;
    @(negedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    raddr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic write(input int a, input logic [DW-1:0] d);
    we    = 1'b1;
    waddr = AW'(a);
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  // Monitor: drains the scoreboard whenever the stimulus raises a sample request.
  always @(negedge clk) begin
    exp_t          e;
    string         n;
    logic [DW-1:0] g;
    cycles++;
    if (req != ack) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n = sb_name.pop_front();
        g = got(e.dut, e.port);
        total++;
        if (g !== e.exp) begin
          bad++;
          $display("FAIL %s: dut%0d port%0d got=%h expected=%h", n, e.dut, e.port, g, e.exp);
        end
      end
      ack = req;
    end
    if (stim_done && sb.size() == 0) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (cycles > 5000) begin
      bad++;
      $display("FAIL watchdog: cycles=%0d pending=%0d expected pending=0", cycles, sb.size());
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    push(0, 0, '0, "reset_a0"); push(0, 1, '0, "reset_a1");
    push(1, 0, '0, "reset_b0"); push(1, 1, '0, "reset_b1"); push(1, 2, '0, "reset_b2");
    push(2, 0, '0, "reset_c0"); push(2, 1, '0, "reset_c1");
    chk();

    // Reset clears a previously written register
    write(5, 32'hDEAD_BEEF);
    set_rd(5, 31, 5);
    tick();
    push(0, 0, 32'hDEAD_BEEF, "r5_a"); push(1, 2, 32'hDEAD_BEEF, "r5_b");
    push(2, 0, 32'hDEAD_BEEF, "r5_c");
    chk();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push(0, 0, '0, "rst_r5_a"); push(0, 1, '0, "rst_r31_a"); push(1, 0, '0, "rst_r5_b");
    push(2, 0, '0, "rst_c0"); push(2, 1, '0, "rst_c1");
    chk();

    // Fill every register, then poke r0 with all ones
    for (int i = 1; i < 32; i++) write(i, pat(i));
    we    = 1'b1;
    waddr = '0;
    wdata = 32'hFFFF_FFFF;
    set_rd(0, 0, 0);
    push(0, 0, '0, "r0_bypass_a"); push(1, 0, '0, "r0_b");
    chk();
    tick();
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_rd(i, 31 - i, i);
      tick();
      push(0, 0, pat(i), "sweep_a0"); push(0, 1, pat(31 - i), "sweep_a1");
      push(1, 2, pat(i), "sweep_b2");
      push(2, 0, pat(i), "sweep_c0"); push(2, 1, pat(31 - i), "sweep_c1");
      chk();
    end

    // Same-cycle bypass versus old data
    tick();
    we    = 1'b1;
    waddr = AW'(7);
    wdata = 32'h1234_5678;
    set_rd(7, 8, 7);
    push(0, 0, 32'h1234_5678, "byp_new_a0"); push(0, 1, pat(8), "byp_other_a1");
    push(1, 0, pat(7), "nobyp_old_b0"); push(1, 1, pat(8), "nobyp_b1");
    push(1, 2, pat(7), "nobyp_old_b2");
    chk();
    tick();
    we = 1'b0;
    push(2, 0, 32'h1234_5678, "lat1_byp_c0"); push(2, 1, pat(8), "lat1_c1");
    push(1, 0, 32'h1234_5678, "r7_written_b0");
    chk();

    // All ports on one address; we=0 edge changes nothing
    write(12, 32'hA5A5_A5A5);
    waddr = AW'(12);
    wdata = '0;
    set_rd(12, 12, 12);
    tick();
    push(0, 0, 32'hA5A5_A5A5, "multi_a0"); push(0, 1, 32'hA5A5_A5A5, "multi_a1");
    push(1, 0, 32'hA5A5_A5A5, "multi_b0"); push(1, 1, 32'hA5A5_A5A5, "multi_b1");
    push(1, 2, 32'hA5A5_A5A5, "multi_b2");
    push(2, 0, 32'hA5A5_A5A5, "multi_c0"); push(2, 1, 32'hA5A5_A5A5, "multi_c1");
    chk();

    // Registered read latency and same-edge write capture
    write(3, 32'h0000_00C3);
    set_rd(3, 12, 12);
    push(2, 0, 32'hA5A5_A5A5, "lat1_before_c0"); push(0, 0, 32'h0000_00C3, "comb_r3_a0");
    chk();
    tick();
    push(2, 0, 32'h0000_00C3, "lat1_after_c0");
    chk();
    write(3, 32'h0000_0077);
    push(2, 0, 32'h0000_0077, "lat1_wr_byp_c0"); push(0, 0, 32'h0000_0077, "r3_new_a0");
    chk();

    // Reset on the same edge as a write
    set_rd(9, 9, 9);
    tick();
    push(2, 0, pat(9), "pre_rst_c0");
    chk();
    we    = 1'b1;
    waddr = AW'(9);
    wdata = 32'h0000_0055;
    rst_n = 1'b0;
    tick();
    we    = 1'b0;
    rst_n = 1'b1;
    push(2, 0, '0, "rst_lat_c0"); push(2, 1, '0, "rst_lat_c1");
    push(0, 0, '0, "rst_r9_a0"); push(1, 0, '0, "rst_r9_b0");
    chk();
    set_rd(12, 3, 9);
    tick();
    push(0, 0, '0, "post_rst_r12_a0"); push(0, 1, '0, "post_rst_r3_a1");
    push(1, 2, '0, "post_rst_r9_b2"); push(2, 0, '0, "post_rst_r12_c0");
    chk();

    stim_done = 1'b1;
  end

endmodule
